// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states, latch control pair, limits.
package pipeline_hazard_sequencer_pkg;

    localparam int unsigned LD_STALL_MAX = 3;
    localparam int unsigned LD_CNT_W     = 2;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DWAIT   = 2'd1,
        LDSTALL = 2'd2,
        HALT    = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard inputs and pipeline latch controls exchanged between the core and the sequencer.
interface pipeline_hazard_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             dmem_req;
    logic             ld_use_hazard;
    logic             branch_taken;
    logic             halt_in;
    logic             pc_en;
    logic             fd_en;
    logic             fd_flush;
    logic             de_en;
    logic             de_flush;
    logic             em_en;
    logic             em_flush;
    logic             mw_en;
    logic             mw_flush;
    logic             halted;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output ihit, dhit, dmem_req, ld_use_hazard, branch_taken, halt_in,
        input  pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, mw_flush, halted, stall_cycles, flush_events
    );

    modport slave (
        input  ihit, dhit, dmem_req, ld_use_hazard, branch_taken, halt_in,
        output pc_en, fd_en, fd_flush, de_en, de_flush, em_en, em_flush,
               mw_en, mw_flush, halted, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_sequencer_perf_counter.sv
// Saturating performance counter with synchronous clear.
module pipe_perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline latch enable/flush sequencer: data wait, load-use bubbles, deferred branch squash, sticky halt.
// Define PIPE_PERF_CNT_EN to build the stall_cycles / flush_events saturating counters.
module pipeline_hazard_sequencer
    import pipeline_hazard_sequencer_pkg::*;
#(
    parameter int unsigned LD_STALL_CYCLES = 1,
    parameter int unsigned CNT_W           = 32
) (
    input logic                        CLK,
    input logic                        RST,
    pipeline_hazard_sequencer_if.slave hz
);

    if ((LD_STALL_CYCLES < 1) || (LD_STALL_CYCLES > LD_STALL_MAX)) begin : g_bad_ld_stall
        $error("LD_STALL_CYCLES must be within 1..3");
    end

    localparam logic [LD_CNT_W-1:0] LD_RELOAD = LD_CNT_W'(LD_STALL_CYCLES - 1);

    hz_state_t           state;
    hz_state_t           state_nxt;
    logic                br_pend;
    logic                br_pend_nxt;
    logic [LD_CNT_W-1:0] ld_cnt;
    logic [LD_CNT_W-1:0] ld_cnt_nxt;
    logic                pc_en;
    logic                halted;
    latch_ctrl_t         fd;
    latch_ctrl_t         de;
    latch_ctrl_t         em;
    latch_ctrl_t         mw;

    // Outputs are a function of the registered state and the current hazard inputs.
    always_comb begin
        pc_en       = 1'b1;
        fd          = '{en: 1'b1, flush: 1'b0};
        de          = '{en: 1'b1, flush: 1'b0};
        em          = '{en: 1'b1, flush: 1'b0};
        mw          = '{en: 1'b1, flush: 1'b0};
        halted      = 1'b0;
        state_nxt   = state;
        br_pend_nxt = br_pend;
        ld_cnt_nxt  = ld_cnt;

        case (state)
            RUN: begin
                if (hz.halt_in) begin
                    pc_en     = 1'b0;
                    fd.en     = 1'b0;
                    de.en     = 1'b0;
                    em        = '{en: 1'b0, flush: 1'b1};
                    state_nxt = HALT;
                end else if (hz.dmem_req && !hz.dhit) begin
                    pc_en       = 1'b0;
                    fd.en       = 1'b0;
                    de.en       = 1'b0;
                    em.en       = 1'b0;
                    mw.flush    = 1'b1;
                    br_pend_nxt = hz.branch_taken;
                    state_nxt   = DWAIT;
                end else if (hz.branch_taken) begin
                    fd.flush = 1'b1;
                    de.flush = 1'b1;
                end else if (hz.ld_use_hazard) begin
                    pc_en    = 1'b0;
                    fd.en    = 1'b0;
                    de.flush = 1'b1;
                    if (LD_STALL_CYCLES > 1) begin
                        ld_cnt_nxt = LD_RELOAD;
                        state_nxt  = LDSTALL;
                    end
                end else if (!hz.ihit) begin
                    pc_en    = 1'b0;
                    fd.flush = 1'b1;
                end
            end

            DWAIT: begin
                if (!hz.dhit) begin
                    pc_en       = 1'b0;
                    fd.en       = 1'b0;
                    de.en       = 1'b0;
                    em.en       = 1'b0;
                    mw.flush    = 1'b1;
                    br_pend_nxt = br_pend | hz.branch_taken;
                end else begin
                    // Release cycle: a branch seen during the wait squashes now.
                    if (br_pend || hz.branch_taken) begin
                        fd.flush = 1'b1;
                        de.flush = 1'b1;
                    end
                    br_pend_nxt = 1'b0;
                    state_nxt   = (ld_cnt != '0) ? LDSTALL : RUN;
                end
            end

            LDSTALL: begin
                if (hz.halt_in) begin
                    pc_en     = 1'b0;
                    fd.en     = 1'b0;
                    de.en     = 1'b0;
                    em        = '{en: 1'b0, flush: 1'b1};
                    state_nxt = HALT;
                end else if (hz.dmem_req && !hz.dhit) begin
                    pc_en       = 1'b0;
                    fd.en       = 1'b0;
                    de.en       = 1'b0;
                    em.en       = 1'b0;
                    mw.flush    = 1'b1;
                    br_pend_nxt = hz.branch_taken;
                    state_nxt   = DWAIT;
                end else begin
                    pc_en      = 1'b0;
                    fd.en      = 1'b0;
                    de.flush   = 1'b1;
                    ld_cnt_nxt = ld_cnt - LD_CNT_W'(1);
                    if (ld_cnt_nxt == '0) begin
                        state_nxt = RUN;
                    end
                end
            end

            HALT: begin
                pc_en  = 1'b0;
                fd     = '{en: 1'b0, flush: 1'b0};
                de     = '{en: 1'b0, flush: 1'b0};
                em     = '{en: 1'b0, flush: 1'b0};
                mw     = '{en: 1'b0, flush: 1'b0};
                halted = 1'b1;
            end

            default: state_nxt = RUN;
        endcase

        if (RST) begin
            pc_en  = 1'b0;
            fd     = '{en: 1'b0, flush: 1'b1};
            de     = '{en: 1'b0, flush: 1'b1};
            em     = '{en: 1'b0, flush: 1'b1};
            mw     = '{en: 1'b0, flush: 1'b1};
            halted = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            br_pend <= 1'b0;
            ld_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            br_pend <= br_pend_nxt;
            ld_cnt  <= ld_cnt_nxt;
        end
    end

    assign hz.pc_en    = pc_en;
    assign hz.fd_en    = fd.en;
    assign hz.fd_flush = fd.flush;
    assign hz.de_en    = de.en;
    assign hz.de_flush = de.flush;
    assign hz.em_en    = em.en;
    assign hz.em_flush = em.flush;
    assign hz.mw_en    = mw.en;
    assign hz.mw_flush = mw.flush;
    assign hz.halted   = halted;

`ifdef PIPE_PERF_CNT_EN
    logic             stall_inc;
    logic             flush_inc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Only a branch squash raises both front flushes while the PC advances.
    assign stall_inc = !pc_en && (state != HALT) && !RST;
    assign flush_inc = pc_en && fd.flush && de.flush;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (CLK),
        .clr (RST),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

    assign hz.stall_cycles = stall_cnt;
    assign hz.flush_events = flush_cnt;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule
